seq_pattern_tx: RTL and testbench

Serial bit-pattern generator that produces the single-bit stream consumed by the team's serial sequence detectors. A WIDTH-bit pattern and a repeat count are accepted over a valid/ready handshake. The pattern is shifted out MSB-first, one bit per clock, (in_repeat+1) times back to back, with a qualifying valid strobe. It then signals completion with a one-cycle done pulse.

---
 rtl/seq_pattern_tx_if.sv | 26 ++
 rtl/seq_pattern_tx.sv | 122 ++++++++++++
 tb/tb_seq_pattern_tx.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-output bundle for seq_pattern_tx.
// The slave modport is the generator side; master is the pattern source/consumer.
interface seq_pattern_tx_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] in_repeat;
    logic             abort;
    logic             q;
    logic             q_valid;
    logic             busy;
    logic             done;

    modport slave (
        input  in_valid, in_data, in_repeat, abort,
        output in_ready, q, q_valid, busy, done
    );

    modport master (
        output in_valid, in_data, in_repeat, abort,
        input  in_ready, q, q_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern generator: shifts a captured WIDTH-bit pattern out MSB-first,
// (in_repeat+1) times back to back, then pulses done for one cycle.
module seq_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    seq_pattern_tx_if.slave  bus
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_pat_reg;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_rep_cnt;
    logic [BW-1:0]    r_bit_cnt;

    logic w_last_bit;
    logic w_rep_zero;
    logic w_in_ready;
    logic w_q;
    logic w_q_valid;
    logic w_busy;
    logic w_done;

    assign w_last_bit = (r_bit_cnt == LAST_BIT);
    assign w_rep_zero = (r_rep_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every comb output gets a default before the case so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid)                  w_next_state = S_SEND;
            S_SEND: begin
                if (bus.abort)                         w_next_state = S_IDLE;
                else if (w_last_bit && w_rep_zero)     w_next_state = S_DONE;
            end
            S_DONE:                                    w_next_state = S_IDLE;
            default:                                   w_next_state = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, shift per bit, reload per extra repetition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat_reg <= '0;
            r_shreg   <= '0;
            r_rep_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_pat_reg <= bus.in_data;
                        r_shreg   <= bus.in_data;
                        r_rep_cnt <= bus.in_repeat;
                        r_bit_cnt <= '0;
                    end
                end
                S_SEND: begin
                    if (bus.abort) begin
                        r_rep_cnt <= '0;
                        r_bit_cnt <= '0;
                    end else if (!w_last_bit) begin
                        r_shreg   <= r_shreg << 1;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end else if (!w_rep_zero) begin
                        r_shreg   <= r_pat_reg;
                        r_bit_cnt <= '0;
                        r_rep_cnt <= r_rep_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs; in_ready additionally gated by rst so it reads 0 during reset.
    always_comb begin
        w_in_ready = 1'b0;
        w_q        = 1'b0;
        w_q_valid  = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: w_in_ready = ~rst;
            S_SEND: begin
                w_busy    = 1'b1;
                w_q_valid = 1'b1;
                w_q       = r_shreg[WIDTH-1];
            end
            S_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.in_ready = w_in_ready;
    assign bus.q        = w_q;
    assign bus.q_valid  = w_q_valid;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: expected streams are built as bit queues
// from the pattern/repeat values and compared cycle by cycle.
module tb_seq_pattern_tx;
    localparam int W = 8;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   accepts[$];

    seq_pattern_tx_if #(.WIDTH(W), .CNT_W(C)) bus ();
    seq_pattern_tx #(.WIDTH(W), .CNT_W(C)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) accepts.push_back(cyc);
        cyc <= cyc + 1;
    end

    // Output vector order: {q, q_valid, busy, done, in_ready}
    function automatic logic [4:0] obs();
        return {bus.q, bus.q_valid, bus.busy, bus.done, bus.in_ready};
    endfunction

    localparam logic [4:0] V_ZERO = 5'b00000;
    localparam logic [4:0] V_IDLE = 5'b00001;
    localparam logic [4:0] V_DONE = 5'b00010;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void build_stream(input logic [W-1:0] pat, input int rep, ref bit q_bits[$]);
        q_bits.delete();
        for (int r = 0; r <= rep; r++)
            for (int k = 0; k < W; k++)
                q_bits.push_back(pat[W-1-k]);
    endfunction

    task automatic launch(input logic [W-1:0] pat, input int rep, input bit hold);
        bus.in_data   = pat;
        bus.in_repeat = C'(rep);
        bus.in_valid  = 1'b1;
        tick();
        if (!hold) bus.in_valid = 1'b0;
    endtask

    // Checks the whole stream starting in the first-bit cycle, then done, then idle.
    task automatic expect_stream(input string tag, input logic [W-1:0] pat, input int rep,
                                 input int change_at);
        bit          q_bits[$];
        logic [4:0]  exp_v;
        build_stream(pat, rep, q_bits);
        for (int i = 0; i < q_bits.size(); i++) begin
            if (i == change_at) bus.in_data = '1;
            exp_v = {q_bits[i], 1'b1, 1'b1, 1'b0, 1'b0};
            n_checks++;
            if (obs() !== exp_v) begin
                n_errors++;
                $display("FAIL %s bit %0d: got %b want %b", tag, i, obs(), exp_v);
            end
            tick();
        end
        n_checks++;
        if (obs() !== V_DONE) begin
            n_errors++;
            $display("FAIL %s done: got %b want %b", tag, obs(), V_DONE);
        end
        tick();
        n_checks++;
        if (obs() !== V_IDLE) begin
            n_errors++;
            $display("FAIL %s idle: got %b want %b", tag, obs(), V_IDLE);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_repeat = '0; bus.abort = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs() !== V_ZERO) begin
                n_errors++;
                $display("FAIL reset cyc %0d: got %b want %b", i, obs(), V_ZERO);
            end
            tick();
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs() !== V_IDLE) begin
            n_errors++;
            $display("FAIL reset release: got %b want %b", obs(), V_IDLE);
        end
        tick();
        n_checks++;
        if (obs() !== V_IDLE) begin
            n_errors++;
            $display("FAIL reset idle: got %b want %b", obs(), V_IDLE);
        end
    endtask

    task automatic test_single();
        launch(8'hB3, 0, 1'b0);
        expect_stream("single", 8'hB3, 0, -1);
    endtask

    task automatic test_repeat();
        launch(8'h03, 2, 1'b0);
        expect_stream("repeat", 8'h03, 2, 4);
    endtask

    task automatic test_back_to_back();
        int base;
        base = accepts.size();
        launch(8'hA5, 0, 1'b1);
        bus.in_data = 8'h5A;
        expect_stream("b2b_a", 8'hA5, 0, -1);
        tick();
        bus.in_valid = 1'b0;
        expect_stream("b2b_b", 8'h5A, 0, -1);
        n_checks++;
        if (accepts.size() != base + 2) begin
            n_errors++;
            $display("FAIL b2b accept count: got %0d want 2", accepts.size() - base);
        end else if (accepts[base+1] - accepts[base] != W + 2) begin
            n_errors++;
            $display("FAIL b2b spacing: got %0d want %0d", accepts[base+1] - accepts[base], W + 2);
        end
    endtask

    task automatic test_abort();
        bit q_bits[$];
        logic [4:0] exp_v;
        build_stream(8'hF0, 0, q_bits);
        launch(8'hF0, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp_v = {q_bits[i], 4'b1100};
            n_checks++;
            if (obs() !== exp_v) begin
                n_errors++;
                $display("FAIL abort bit %0d: got %b want %b", i, obs(), exp_v);
            end
            if (i == 1) bus.abort = 1'b1;
            tick();
        end
        bus.abort = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            n_checks++;
            if (obs() !== V_IDLE) begin
                n_errors++;
                $display("FAIL abort idle %0d: got %b want %b", i, obs(), V_IDLE);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        bit q_bits[$];
        logic [4:0] exp_v;
        build_stream(8'hC6, 3, q_bits);
        launch(8'hC6, 3, 1'b0);
        for (int i = 0; i <= W + 2; i++) begin
            exp_v = {q_bits[i], 4'b1100};
            n_checks++;
            if (obs() !== exp_v) begin
                n_errors++;
                $display("FAIL arst bit %0d: got %b want %b", i, obs(), exp_v);
            end
            if (i < W + 2) tick();
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs() !== V_ZERO) begin
            n_errors++;
            $display("FAIL arst during: got %b want %b", obs(), V_ZERO);
        end
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 2 * W; i++) begin
            n_checks++;
            if (obs() !== V_IDLE) begin
                n_errors++;
                $display("FAIL arst idle %0d: got %b want %b", i, obs(), V_IDLE);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] pat;
        int rep;
        for (int n = 0; n < 8; n++) begin
            pat = W'($urandom);
            rep = $urandom_range(0, 3);
            launch(pat, rep, 1'b0);
            expect_stream($sformatf("rand%0d", n), pat, rep, -1);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
